game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 25 ++
 rtl/game_rise_detect.sv | 23 ++
 rtl/game_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game controller: FSM state codes and screen geometry.
// The best-score tracker in game_controller is built only when HIGH_SCORE_EN is defined.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int SCREEN_HEIGHT = 480;
    localparam int BIRD_HEIGHT   = 16;
    localparam int GROUND_Y      = BIRD_HEIGHT;
    localparam int BIRD_Y_W      = 11;

    localparam logic signed [BIRD_Y_W-1:0] GROUND_Y_S = BIRD_Y_W'(GROUND_Y);

    // The bird is down once its (up-positive) position reaches the ground line.
    function automatic logic on_ground(input logic signed [BIRD_Y_W-1:0] y);
        return (y <= GROUND_Y_S);
    endfunction

endpackage

// File: rtl/game_rise_detect.sv
// Rising-edge detector for an input already synchronous to clk.
// The previous-value register resets to 1 so a level held through reset release is not a press.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic prev_q;

    // Remember the last sampled level; reset high to swallow a held input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= in;
        end
    end

    assign pulse = in & ~prev_q;

endmodule

// File: rtl/game_controller.sv
// Game flow controller: IDLE -> READY countdown -> PLAY -> DEAD countdown -> OVER.
// Define HIGH_SCORE_EN to build the best-score register; otherwise best_score is tied to 0.
module game_controller
    import game_pkg::*;
#(
    parameter int READY_TICKS = 120,
    parameter int DEATH_TICKS = 60,
    parameter int SCORE_WIDTH = 10
) (
    input  logic                          gameClk,
    input  logic                          reset,
    input  logic                          button,
    input  logic signed [BIRD_Y_W-1:0]    bird_y,
    input  logic                          collide,
    input  logic                          pipe_passed,
    output logic                          flap,
    output logic                          bird_restart,
    output logic                          finished,
    output logic [2:0]                    state,
    output logic [SCORE_WIDTH-1:0]        score,
    output logic [SCORE_WIDTH-1:0]        best_score
);

    localparam int MAX_TICKS = (READY_TICKS > DEATH_TICKS) ? READY_TICKS : DEATH_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] READY_LOAD = CNT_W'(READY_TICKS - 1);
    localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_TICKS - 1);

    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   restart_q, restart_d;
    logic                   finished_q;
    logic                   press;
    logic                   death;
    logic                   cnt_zero;

    rise_detect u_press (
        .clk   (gameClk),
        .rst   (reset),
        .in    (button),
        .pulse (press)
    );

    assign death    = collide | on_ground(bird_y);
    assign cnt_zero = (cnt_q == '0);

    // State register.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused codes fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (press)    state_d = ST_READY;
            ST_READY: if (cnt_zero) state_d = ST_PLAY;
            ST_PLAY:  if (death)    state_d = ST_DEAD;
            ST_DEAD:  if (cnt_zero) state_d = ST_OVER;
            ST_OVER:  if (press)    state_d = ST_READY;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values: flap is combinational, the rest feed registers.
    always_comb begin
        flap      = 1'b0;
        restart_d = 1'b0;
        cnt_d     = cnt_q;
        score_d   = score_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (press) begin
                    restart_d = 1'b1;
                    cnt_d     = READY_LOAD;
                    score_d   = '0;
                end
            end
            ST_READY, ST_DEAD: begin
                if (!cnt_zero) cnt_d = cnt_q - 1'b1;
            end
            ST_PLAY: begin
                flap = press;
                // Death wins over a simultaneous pipe pass: no point is awarded.
                if (death) begin
                    cnt_d = DEATH_LOAD;
                end else if (pipe_passed && (score_q != '1)) begin
                    score_d = score_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: countdown, score, restart pulse and the motion freeze flag.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            score_q    <= '0;
            restart_q  <= 1'b0;
            finished_q <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            score_q    <= score_d;
            restart_q  <= restart_d;
            finished_q <= (state_d != ST_PLAY);
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_WIDTH-1:0] best_q;

    // Capture the running maximum on each PLAY -> DEAD transition.
    always_ff @(posedge gameClk or posedge reset) begin
        if (reset) begin
            best_q <= '0;
        end else if ((state_q == ST_PLAY) && (state_d == ST_DEAD) && (score_d > best_q)) begin
            best_q <= score_d;
        end
    end

    assign best_score = best_q;
`else
    assign best_score = '0;
`endif

    assign state        = state_q;
    assign score        = score_q;
    assign bird_restart = restart_q;
    assign finished     = finished_q;

endmodule
